// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared encodings for the execute stage and its mul/div unit
package execute_pkg;

    typedef enum logic [1:0] {
        MD_MUL   = 2'b00,
        MD_MULHU = 2'b01,
        MD_DIVU  = 2'b10,
        MD_REMU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_t;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_AND    = 2;
    localparam int ALU_OR     = 3;
    localparam int ALU_XOR    = 4;
    localparam int ALU_SLL    = 5;
    localparam int ALU_SRL    = 6;
    localparam int ALU_SRA    = 7;
    localparam int ALU_SLT    = 8;
    localparam int ALU_SLTU   = 9;
    localparam int ALU_PASS_B = 10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU of the execute stage
module alu
    import execute_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    localparam int SH_W = $clog2(XLEN);

    always_comb begin
        y = '0;
        case (op)
            OP_W'(ALU_ADD):    y = a + b;
            OP_W'(ALU_SUB):    y = a - b;
            OP_W'(ALU_AND):    y = a & b;
            OP_W'(ALU_OR):     y = a | b;
            OP_W'(ALU_XOR):    y = a ^ b;
            OP_W'(ALU_SLL):    y = a << b[SH_W-1:0];
            OP_W'(ALU_SRL):    y = a >> b[SH_W-1:0];
            OP_W'(ALU_SRA):    y = $signed(a) >>> b[SH_W-1:0];
            OP_W'(ALU_SLT):    y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_W'(ALU_SLTU):   y = {{(XLEN-1){1'b0}}, (a < b)};
            OP_W'(ALU_PASS_B): y = b;
            default:           y = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            abort,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   b_q;
    // Upper half: partial product / remainder. Lower half: multiplier / dividend -> quotient.
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic              last;

    assign last = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_RUN;
            MD_RUN:  if (last)  state_d = MD_DONE;
            MD_DONE: if (ack)   state_d = MD_IDLE;
            default:            state_d = MD_IDLE;
        endcase
        if (abort) state_d = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    always_comb begin
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = rem_sh - {1'b0, b_q};
        acc_next = acc_q;
        if (!op_q[1])
            acc_next = {sum, acc_q[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            acc_q <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
        end else if (state_q == MD_IDLE && start) begin
            op_q  <= op;
            b_q   <= b;
            acc_q <= {{XLEN{1'b0}}, a};
            cnt_q <= '0;
        end else if (state_q == MD_RUN) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign busy   = (state_q == MD_IDLE && start) || (state_q == MD_RUN);
    assign done   = (state_q == MD_DONE);
    assign result = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
endmodule

// File: rtl/execute_md.sv
// rtl/execute_md.sv - execute stage: D/E register, forwarding, ALU and iterative mul/div
module execute_md
    import execute_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_d,
    input  logic                rd_write_d,
    input  logic [1:0]          rd_write_src_d,
    input  logic                mem_write_d,
    input  logic [ALU_OP_W-1:0] alu_op_d,
    input  logic                alu_src_a_d,
    input  logic                alu_src_b_d,
    input  logic                md_en_d,
    input  logic [1:0]          md_op_d,
    input  logic [REG_AW-1:0]   rd_d,
    input  logic [REG_AW-1:0]   rs1_d,
    input  logic [REG_AW-1:0]   rs2_d,
    input  logic [XLEN-1:0]     imm_d,
    input  logic [XLEN-1:0]     pc_d,
    input  logic [XLEN-1:0]     rs1_data_d,
    input  logic [XLEN-1:0]     rs2_data_d,
    input  logic [XLEN-1:0]     alu_res_m,
    input  logic [XLEN-1:0]     rd_data_w,
    input  logic                stall_e,
    input  logic                flush_e,
    input  logic [1:0]          fwd_rs1_e,
    input  logic [1:0]          fwd_rs2_e,
    output logic                issue_e,
    output logic                rd_write_e,
    output logic                mem_write_e,
    output logic [1:0]          rd_write_src_e,
    output logic [REG_AW-1:0]   rd_e,
    output logic [REG_AW-1:0]   rs1_e,
    output logic [REG_AW-1:0]   rs2_e,
    output logic [XLEN-1:0]     pc_e,
    output logic [XLEN-1:0]     res_e,
    output logic [XLEN-1:0]     mem_data_e,
    output logic                md_busy_e
);
    logic                valid_q, rd_write_q, mem_write_q, alu_src_a_q, alu_src_b_q, md_en_q;
    logic [1:0]          rd_write_src_q, md_op_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
    logic [XLEN-1:0]     imm_q, pc_q, rs1_data_q, rs2_data_q;
    logic [XLEN-1:0]     rs1_fwd, rs2_fwd, src_a, src_b, alu_y, md_result;
    logic                load, clear, md_done;

    assign clear = rst || flush_e;
    assign load  = !stall_e && !md_busy_e;

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= 1'b0;       rd_write_q <= 1'b0;     mem_write_q <= 1'b0;
            alu_src_a_q <= 1'b0;   alu_src_b_q <= 1'b0;    md_en_q <= 1'b0;
            rd_write_src_q <= '0;  md_op_q <= '0;          alu_op_q <= '0;
            rd_q <= '0;            rs1_q <= '0;            rs2_q <= '0;
            imm_q <= '0;           pc_q <= '0;
            rs1_data_q <= '0;      rs2_data_q <= '0;
        end else if (load) begin
            valid_q <= valid_d;             rd_write_q <= rd_write_d;   mem_write_q <= mem_write_d;
            alu_src_a_q <= alu_src_a_d;     alu_src_b_q <= alu_src_b_d; md_en_q <= md_en_d;
            rd_write_src_q <= rd_write_src_d; md_op_q <= md_op_d;       alu_op_q <= alu_op_d;
            rd_q <= rd_d;                   rs1_q <= rs1_d;             rs2_q <= rs2_d;
            imm_q <= imm_d;                 pc_q <= pc_d;
            rs1_data_q <= rs1_data_d;       rs2_data_q <= rs2_data_d;
        end
    end

    always_comb begin
        case (fwd_sel_t'(fwd_rs1_e))
            FWD_WB:  rs1_fwd = rd_data_w;
            FWD_MEM: rs1_fwd = alu_res_m;
            default: rs1_fwd = rs1_data_q;
        endcase
        case (fwd_sel_t'(fwd_rs2_e))
            FWD_WB:  rs2_fwd = rd_data_w;
            FWD_MEM: rs2_fwd = alu_res_m;
            default: rs2_fwd = rs2_data_q;
        endcase
    end

    assign src_a = (alu_src_a_q == SRC_A_PC)  ? pc_q  : rs1_fwd;
    assign src_b = (alu_src_b_q == SRC_B_IMM) ? imm_q : rs2_fwd;

    alu #(.XLEN(XLEN), .OP_W(ALU_OP_W)) u_alu (
        .op (alu_op_q),
        .a  (src_a),
        .b  (src_b),
        .y  (alu_y)
    );

    // DONE is released on the same edge the next instruction enters the E register.
    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .start  (valid_q && md_en_q),
        .op     (md_op_q),
        .a      (rs1_fwd),
        .b      (rs2_fwd),
        .abort  (clear),
        .ack    (load),
        .busy   (md_busy_e),
        .done   (md_done),
        .result (md_result)
    );

    assign issue_e        = valid_q && !md_busy_e;
    assign rd_write_e     = rd_write_q && issue_e;
    assign mem_write_e    = mem_write_q && issue_e;
    assign rd_write_src_e = rd_write_src_q;
    assign rd_e           = rd_q;
    assign rs1_e          = rs1_q;
    assign rs2_e          = rs2_q;
    assign pc_e           = pc_q;
    assign res_e          = md_done ? md_result : alu_y;
    assign mem_data_e     = rs2_fwd;
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised next-generation EXECUTE (_e) stage of the 5-stage RISC-V pipeline.
- Keeps the existing job: D/E pipeline register, rs1/rs2 forwarding muxes, ALU operand selection and ALU.
- Adds an iterative multiply/divide unit (MUL, MULHU, DIVU, REMU) that holds the stage busy. The hazard unit receives md_busy_e, and the memory stage receives a qualified issue_e.
- Sits between decode and memory.

Parameters:
XLEN, 32, datapath width (>=8, even)
REG_AW, 5, register-address width
ALU_OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_d  in  1  decode slot holds a real instruction
rd_write_d  in  1  writes rd
rd_write_src_d  in  2  writeback source select, passed through
mem_write_d  in  1  store
alu_op_d  in  ALU_OP_W  ALU opcode
alu_src_a_d  in  1  0: rs1, 1: pc
alu_src_b_d  in  1  0: rs2, 1: imm_d
md_en_d  in  1  instruction uses the mul/div unit
md_op_d  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
rd_d, rs1_d, rs2_d  in  REG_AW  register addresses
imm_d  in  XLEN  selected immediate
pc_d  in  XLEN  instruction pc
rs1_data_d, rs2_data_d  in  XLEN  register-file data
alu_res_m  in  XLEN  memory-stage forward value
rd_data_w  in  XLEN  writeback forward value
stall_e  in  1  hold E register
flush_e  in  1  bubble E register
fwd_rs1_e, fwd_rs2_e  in  2  00 reg, 01 writeback, 10 memory, 11 reg
issue_e  out  1  valid_e and not md_busy_e
rd_write_e, mem_write_e  out  1  gated with issue_e
rd_write_src_e  out  2  registered
rd_e, rs1_e, rs2_e  out  REG_AW  registered
pc_e  out  XLEN  registered
res_e  out  XLEN  md result in DONE, else ALU result
mem_data_e  out  XLEN  forwarded rs2
md_busy_e  out  1  stall request to hazard unit

Behaviour:
- E register load and clear:
  - Priority order: rst, then flush_e, then load.
  - rst or flush_e clears all E registers to 0 on the clock edge and forces the FSM to IDLE. This includes abort of any mul/div in flight.
  - Otherwise the E register loads from the decode inputs when !stall_e && !md_busy_e; it holds otherwise.
- Reset values: every output is 0 (md_busy_e=0, issue_e=0).
- Forwarding: 2-bit selects are combinational per the encoding above. Code 11 is treated as 00.
- ALU path: combinational, zero added latency.
  - src_a = alu_src_a_e ? pc_e : fwd rs1.
  - src_b = alu_src_b_e ? imm_e : fwd rs2.
- Mul/div FSM states: IDLE, RUN, DONE.
  - IDLE with valid_e && md_en_e: md_busy_e=1 combinationally. Capture the forwarded operands that cycle; forward sources are not re-sampled afterwards. Clear the counter, go to RUN.
  - RUN: one iteration per cycle, md_busy_e=1. When counter == XLEN-1, go to DONE.
    - MUL/MULHU: shift-add into a 2*XLEN accumulator.
    - DIVU/REMU: restoring divide.
  - DONE: md_busy_e=0 and res_e = md result. Stay in DONE while stall_e=1 (res_e stable). Go to IDLE on the edge where the E register loads.
- Latency: md_busy_e is high for exactly XLEN+1 cycles. issue_e rises on the following cycle.
- Results:
  - MUL returns the low XLEN bits; MULHU returns the high XLEN bits.
  - Divide by 0: DIVU returns all-ones and REMU returns the dividend (RISC-V semantics, with no trap).
- Non-md instructions never assert md_busy_e.
- A stall_e asserted while in RUN does not pause iteration.
- Decode inputs presented while md_busy_e=1 are not lost: the E register does not load, and decode holds them via the hazard unit.

Decomposition:
- Package execute_pkg holds: md_op encodings, fwd-select encodings, alu_src encodings, and the FSM state type.
- Sub-module muldiv_iter (parameter XLEN) contains the FSM, counter, accumulator and divider.
  - Inputs: start, op, a, b, abort.
  - Outputs: busy, done, result.
- The existing alu module is reused as-is.

Test Plan:
1. ADD, rs1_data_d=5, fwd_rs1_e=10 with alu_res_m=7, imm_d=3, alu_src_b=1 -> res_e=10, issue_e=1 in the same cycle, md_busy_e=0.
2. MUL 0x0000FFFF*0x00010001 -> md_busy_e high for 33 cycles; cycle 34 gives issue_e=1 and res_e=0xFFFFFFFF. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
3. DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 13/0 -> 13.
4. MUL entry with fwd_rs1_e=10 (alu_res_m=9), then alu_res_m changes to 1 during RUN -> product uses 9.
5. flush_e at RUN cycle 10 -> next cycle md_busy_e=0 and all outputs 0. The following ADD completes normally. Repeat with rst at RUN cycle 10 -> same result.
6. DIVU reaches DONE with stall_e held for 3 cycles -> res_e stable and md_busy_e=0 throughout. FSM returns to IDLE on the load edge after stall_e drops.
